// File: rtl/idex_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/bubble insertion
// and a saturating bubble counter. Hazard detection is compiled in by HAZARD_DETECT_EN.
module idex_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ID_ctlwb,
    input  logic [2:0]       ID_ctlm,
    input  logic [3:0]       ID_ctlex,
    input  logic [WIDTH-1:0] ID_npc,
    input  logic [WIDTH-1:0] ID_readdat1,
    input  logic [WIDTH-1:0] ID_readdat2,
    input  logic [WIDTH-1:0] ID_signext,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic [4:0]       ID_rd,
    input  logic             flush,
    output logic [1:0]       EX_ctlwb,
    output logic [2:0]       EX_ctlm,
    output logic [3:0]       EX_ctlex,
    output logic [WIDTH-1:0] EX_npc,
    output logic [WIDTH-1:0] EX_readdat1,
    output logic [WIDTH-1:0] EX_readdat2,
    output logic [WIDTH-1:0] EX_signext,
    output logic [4:0]       EX_rs,
    output logic [4:0]       EX_rt,
    output logic [4:0]       EX_rd,
    output logic             ID_stall,
    output logic [15:0]      bubble_cnt
);

    logic hazard;
    logic bubble;

`ifdef HAZARD_DETECT_EN
    // rt is compared for every opcode; occasional spurious stalls are accepted
    assign hazard = EX_ctlm[1] & (EX_rt != 5'd0) &
                    ((EX_rt == ID_rs) | (EX_rt == ID_rt));
`else
    assign hazard = 1'b0;
`endif

    assign ID_stall = hazard & ~flush;
    assign bubble   = flush | hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EX_ctlwb    <= '0;
            EX_ctlm     <= '0;
            EX_ctlex    <= '0;
            EX_npc      <= '0;
            EX_readdat1 <= '0;
            EX_readdat2 <= '0;
            EX_signext  <= '0;
            EX_rs       <= '0;
            EX_rt       <= '0;
            EX_rd       <= '0;
        end else if (flush) begin
            EX_ctlwb    <= '0;
            EX_ctlm     <= '0;
            EX_ctlex    <= '0;
            EX_npc      <= '0;
            EX_readdat1 <= '0;
            EX_readdat2 <= '0;
            EX_signext  <= '0;
            EX_rs       <= '0;
            EX_rt       <= '0;
            EX_rd       <= '0;
        end else begin
            // A hazard bubble only kills control; clearing MemRead ends the stall next cycle
            if (hazard) begin
                EX_ctlwb <= '0;
                EX_ctlm  <= '0;
                EX_ctlex <= '0;
            end else begin
                EX_ctlwb <= ID_ctlwb;
                EX_ctlm  <= ID_ctlm;
                EX_ctlex <= ID_ctlex;
            end
            EX_npc      <= ID_npc;
            EX_readdat1 <= ID_readdat1;
            EX_readdat2 <= ID_readdat2;
            EX_signext  <= ID_signext;
            EX_rs       <= ID_rs;
            EX_rt       <= ID_rt;
            EX_rd       <= ID_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (bubble && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_idex_reg.sv
// Directed, table-driven bench for idex_reg; expectations adapt to HAZARD_DETECT_EN.
module tb_idex_reg;

`ifdef HAZARD_DETECT_EN
    localparam bit HD = 1'b1;
`else
    localparam bit HD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [1:0]  ID_ctlwb;
    logic [2:0]  ID_ctlm;
    logic [3:0]  ID_ctlex;
    logic [31:0] ID_npc, ID_readdat1, ID_readdat2, ID_signext;
    logic [4:0]  ID_rs, ID_rt, ID_rd;
    logic        flush;
    logic [1:0]  EX_ctlwb;
    logic [2:0]  EX_ctlm;
    logic [3:0]  EX_ctlex;
    logic [31:0] EX_npc, EX_readdat1, EX_readdat2, EX_signext;
    logic [4:0]  EX_rs, EX_rt, EX_rd;
    logic        ID_stall;
    logic [15:0] bubble_cnt;

    idex_reg #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_ctlwb(ID_ctlwb), .ID_ctlm(ID_ctlm), .ID_ctlex(ID_ctlex),
        .ID_npc(ID_npc), .ID_readdat1(ID_readdat1), .ID_readdat2(ID_readdat2),
        .ID_signext(ID_signext), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
        .flush(flush),
        .EX_ctlwb(EX_ctlwb), .EX_ctlm(EX_ctlm), .EX_ctlex(EX_ctlex),
        .EX_npc(EX_npc), .EX_readdat1(EX_readdat1), .EX_readdat2(EX_readdat2),
        .EX_signext(EX_signext), .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd),
        .ID_stall(ID_stall), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // hz is the hand-derived load-use condition given the EX contents left by the previous row
    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc, rd1, rd2, se;
        logic [4:0]  rs, rt, rd;
        logic        fl;
        logic        hz;
    } vec_t;

    vec_t vecs[11];
    int   checks = 0;
    int   passed = 0;
    logic [15:0] exp_cnt;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " ctlwb"}, 32'(EX_ctlwb), 32'h0);
        checkOutput({tag, " ctlm"}, 32'(EX_ctlm), 32'h0);
        checkOutput({tag, " ctlex"}, 32'(EX_ctlex), 32'h0);
        checkOutput({tag, " npc"}, EX_npc, 32'h0);
        checkOutput({tag, " rd1"}, EX_readdat1, 32'h0);
        checkOutput({tag, " rd2"}, EX_readdat2, 32'h0);
        checkOutput({tag, " se"}, EX_signext, 32'h0);
        checkOutput({tag, " rs"}, 32'(EX_rs), 32'h0);
        checkOutput({tag, " rt"}, 32'(EX_rt), 32'h0);
        checkOutput({tag, " rd"}, 32'(EX_rd), 32'h0);
        checkOutput({tag, " cnt"}, 32'(bubble_cnt), 32'h0);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic ctl_zero;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        ID_ctlwb = v.wb; ID_ctlm = v.m; ID_ctlex = v.ex;
        ID_npc = v.npc; ID_readdat1 = v.rd1; ID_readdat2 = v.rd2; ID_signext = v.se;
        ID_rs = v.rs; ID_rt = v.rt; ID_rd = v.rd; flush = v.fl;
        #1;
        checkOutput({tag, " stall"}, 32'(ID_stall), 32'(v.hz & ~v.fl & HD));
        ctl_zero = v.fl | (v.hz & HD);
        if (ctl_zero) exp_cnt = exp_cnt + 16'd1;
        @(posedge clk);
        #1;
        checkOutput({tag, " ctlwb"}, 32'(EX_ctlwb), ctl_zero ? 32'h0 : 32'(v.wb));
        checkOutput({tag, " ctlm"}, 32'(EX_ctlm), ctl_zero ? 32'h0 : 32'(v.m));
        checkOutput({tag, " ctlex"}, 32'(EX_ctlex), ctl_zero ? 32'h0 : 32'(v.ex));
        checkOutput({tag, " npc"}, EX_npc, v.fl ? 32'h0 : v.npc);
        checkOutput({tag, " rd1"}, EX_readdat1, v.fl ? 32'h0 : v.rd1);
        checkOutput({tag, " rd2"}, EX_readdat2, v.fl ? 32'h0 : v.rd2);
        checkOutput({tag, " se"}, EX_signext, v.fl ? 32'h0 : v.se);
        checkOutput({tag, " rs"}, 32'(EX_rs), v.fl ? 32'h0 : 32'(v.rs));
        checkOutput({tag, " rt"}, 32'(EX_rt), v.fl ? 32'h0 : 32'(v.rt));
        checkOutput({tag, " rd"}, 32'(EX_rd), v.fl ? 32'h0 : 32'(v.rd));
        checkOutput({tag, " cnt"}, 32'(bubble_cnt), 32'(exp_cnt));
    endtask

    initial begin
        vecs[0]  = '{2'b10, 3'b000, 4'b1100, 32'h4,  32'h1234_5678, 32'h0,    32'h0,    5'd1,  5'd2,  5'd8,  1'b0, 1'b0};
        vecs[1]  = '{2'b11, 3'b010, 4'b0001, 32'h8,  32'hAA,        32'hBB,   32'h10,   5'd3,  5'd9,  5'd0,  1'b0, 1'b0};
        vecs[2]  = '{2'b10, 3'b000, 4'b1100, 32'hC,  32'h11,        32'h22,   32'h33,   5'd9,  5'd4,  5'd5,  1'b0, 1'b1};
        vecs[3]  = '{2'b10, 3'b000, 4'b1010, 32'h10, 32'h44,        32'h55,   32'h66,   5'd4,  5'd4,  5'd6,  1'b0, 1'b0};
        vecs[4]  = '{2'b11, 3'b010, 4'b0001, 32'h14, 32'h77,        32'h88,   32'h4,    5'd2,  5'd0,  5'd0,  1'b0, 1'b0};
        vecs[5]  = '{2'b10, 3'b000, 4'b1100, 32'h18, 32'h99,        32'hAB,   32'hCD,   5'd0,  5'd0,  5'd3,  1'b0, 1'b0};
        vecs[6]  = '{2'b11, 3'b010, 4'b0001, 32'h1C, 32'h1,         32'h2,    32'h3,    5'd1,  5'd9,  5'd0,  1'b0, 1'b0};
        vecs[7]  = '{2'b10, 3'b000, 4'b1100, 32'h20, 32'hDEAD,      32'hBEEF, 32'h5,    5'd9,  5'd3,  5'd4,  1'b1, 1'b1};
        vecs[8]  = '{2'b11, 3'b010, 4'b0011, 32'h24, 32'h5,         32'h6,    32'h7,    5'd1,  5'd7,  5'd0,  1'b0, 1'b0};
        vecs[9]  = '{2'b10, 3'b100, 4'b1100, 32'h28, 32'h8,         32'h9,    32'hA,    5'd2,  5'd7,  5'd11, 1'b0, 1'b1};
        vecs[10] = '{2'b10, 3'b001, 4'b0100, 32'h2C, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF0, 5'd31, 5'd30, 5'd29, 1'b0, 1'b0};

        rst_n = 1'b0; flush = 1'b0;
        ID_ctlwb = '0; ID_ctlm = '0; ID_ctlex = '0;
        ID_npc = '0; ID_readdat1 = '0; ID_readdat2 = '0; ID_signext = '0;
        ID_rs = '0; ID_rt = '0; ID_rd = '0;
        exp_cnt = '0;
        #12;
        checkAllZero("reset");
        checkOutput("reset stall", 32'(ID_stall), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

        // Asynchronous reset between edges must clear everything without a clock
        #3;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation: 65534 flushes reach FFFE, further flushes pin the count at FFFF
        flush = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        checkOutput("sat FFFE", 32'(bubble_cnt), 32'h0000_FFFE);
        checkOutput("sat flush stall", 32'(ID_stall), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("sat FFFF", 32'(bubble_cnt), 32'h0000_FFFF);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("sat hold", 32'(bubble_cnt), 32'h0000_FFFF);
        @(negedge clk);
        flush = 1'b0;

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
